// File: rtl/exc_ctrl.sv
// ----------------------------------------------------------------------------
// exc_ctrl -- exception / interrupt control stage behind the main decoder.
//
// Takes the decoder status (EStatus, ERet) and produces the registered
// interrupt request (ExtIRQ) that the decoder samples. It also holds the
// exception link (ELR) and syndrome (ESR) registers and selects the next-PC
// source. A RUN / HANDLER / HALT state machine sequences entry, return and
// double-fault halt. The raw interrupt line uses a request/acknowledge
// handshake.
//
// Optional build macro: EXC_COUNT_EN
//   defined   -> 16-bit saturating ExcCount of exceptions taken
//   undefined -> counter not built, ExcCount reads 16'h0000
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low
//   PC_id      in   PC of the instruction in decode
//   EStatus    in   0000 none, 0001 ext IRQ, 0010 invalid opcode, others reserved
//   ERet       in   decoder flags an ERET
//   NotAnInstr in   decoder invalid-opcode flag (EStatus is authoritative)
//   IrqReq     in   raw level interrupt line
//   ExtIRQ     out  registered IRQ request to the decoder
//   IrqAck     out  one-cycle acknowledge to the interrupt source
//   ExcPCSel   out  00 PC+4/branch, 01 EXC_VECTOR, 10 ELR, 11 hold PC
//   ExcVector  out  constant handler entry address
//   ELR        out  saved PC
//   ESR        out  saved syndrome
//   InHandler  out  state is HANDLER
//   Halted     out  state is HALT
//   ExcCount   out  exceptions taken (optional)
// ----------------------------------------------------------------------------
module exc_ctrl #(
    parameter int           N          = 64,
    parameter logic [N-1:0] EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] PC_id,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic         NotAnInstr,
    input  logic         IrqReq,
    output logic         ExtIRQ,
    output logic         IrqAck,
    output logic [1:0]   ExcPCSel,
    output logic [N-1:0] ExcVector,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic         InHandler,
    output logic         Halted,
    output logic [15:0]  ExcCount
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  pc_sel;
    logic        take;
    logic        dfault;
    logic        irq_q;
    logic        pending;
    logic        irq_rise;
    logic        pending_nx;

    // EStatus already encodes invalid opcodes, so the raw flag carries no
    // extra information here.
    logic unused_not_an_instr;
    assign unused_not_an_instr = NotAnInstr;

    assign ExcVector = EXC_VECTOR;

    // Next-state and PC-source selection. Inside the handler any non-zero
    // status is a double fault and wins over ERet.
    always_comb begin
        state_nx = state;
        pc_sel   = 2'b00;
        take     = 1'b0;
        dfault   = 1'b0;
        case (state)
            ST_RUN: begin
                if (EStatus != 4'd0) begin
                    take     = 1'b1;
                    pc_sel   = 2'b01;
                    state_nx = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (EStatus != 4'd0) begin
                    dfault   = 1'b1;
                    pc_sel   = 2'b11;
                    state_nx = ST_HALT;
                end else if (ERet) begin
                    pc_sel   = 2'b10;
                    state_nx = ST_RUN;
                end
            end
            ST_HALT: begin
                pc_sel = 2'b11;
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase
    end

    // Combinational outputs read as idle while reset is held, even if the
    // decoder presents a status during reset.
    assign ExcPCSel  = reset ? pc_sel : 2'b00;
    assign InHandler = reset & (state == ST_HANDLER);
    assign Halted    = reset & (state == ST_HALT);

    // A rising edge that coincides with the acknowledge must survive the
    // clear, otherwise a second request would be silently dropped.
    assign irq_rise   = IrqReq & ~irq_q;
    assign pending_nx = irq_rise | (pending & ~IrqAck);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_RUN;
            irq_q   <= 1'b0;
            pending <= 1'b0;
            ExtIRQ  <= 1'b0;
            IrqAck  <= 1'b0;
            ELR     <= '0;
            ESR     <= 4'd0;
        end else begin
            state   <= state_nx;
            irq_q   <= IrqReq;
            pending <= pending_nx;
            // Qualified by the next state so the request drops in the same
            // edge that enters the handler: no nesting.
            ExtIRQ  <= pending & (state_nx == ST_RUN);
            IrqAck  <= take & (EStatus == 4'b0001);
            if (take) begin
                ELR <= PC_id;
            end
            if (take || dfault) begin
                ESR <= EStatus;
            end
        end
    end

`ifdef EXC_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] exc_cnt;

    // Only RUN->HANDLER entries count; double faults do not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_cnt <= 16'd0;
        end else if (take) begin
            exc_cnt <= sat_inc16(exc_cnt);
        end
    end

    assign ExcCount = exc_cnt;
`else
    assign ExcCount = 16'h0000;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

    localparam int N = 64;
`ifdef EXC_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] PC_id;
    logic [3:0]   EStatus;
    logic         ERet;
    logic         NotAnInstr;
    logic         IrqReq;
    logic         ExtIRQ;
    logic         IrqAck;
    logic [1:0]   ExcPCSel;
    logic [N-1:0] ExcVector;
    logic [N-1:0] ELR;
    logic [3:0]   ESR;
    logic         InHandler;
    logic         Halted;
    logic [15:0]  ExcCount;

    int errors = 0;
    int checks = 0;
    int takes  = 0;

    exc_ctrl #(.N(N), .EXC_VECTOR(64'h0000_0000_0000_00D8)) dut (
        .clk       (clk),
        .reset     (reset),
        .PC_id     (PC_id),
        .EStatus   (EStatus),
        .ERet      (ERet),
        .NotAnInstr(NotAnInstr),
        .IrqReq    (IrqReq),
        .ExtIRQ    (ExtIRQ),
        .IrqAck    (IrqAck),
        .ExcPCSel  (ExcPCSel),
        .ExcVector (ExcVector),
        .ELR       (ELR),
        .ESR       (ESR),
        .InHandler (InHandler),
        .Halted    (Halted),
        .ExcCount  (ExcCount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_cnt();
        return CNT_EN ? takes[15:0] : 16'h0000;
    endfunction

    task automatic test_reset();
        reset = 1'b0; PC_id = '0; EStatus = 4'd0; ERet = 1'b0;
        NotAnInstr = 1'b0; IrqReq = 1'b0;
        step(); step();
        EStatus = 4'b0010;
        #1;
        checks++; if (ExcPCSel !== 2'b00) begin errors++; $display("FAIL rst_sel got=%b exp=00", ExcPCSel); end
        checks++; if (ExtIRQ !== 1'b0 || IrqAck !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b%b exp=00", ExtIRQ, IrqAck); end
        checks++; if (InHandler !== 1'b0 || Halted !== 1'b0) begin errors++; $display("FAIL rst_state got=%b%b exp=00", InHandler, Halted); end
        EStatus = 4'd0;
        step();
        reset = 1'b1;
        repeat (5) step();
        checks++; if (ExcPCSel !== 2'b00) begin errors++; $display("FAIL idle_sel got=%b exp=00", ExcPCSel); end
        checks++; if (ExtIRQ !== 1'b0) begin errors++; $display("FAIL idle_extirq got=%b exp=0", ExtIRQ); end
        checks++; if (ELR !== 64'h0 || ESR !== 4'h0) begin errors++; $display("FAIL idle_elr_esr got=%h/%h exp=0/0", ELR, ESR); end
        checks++; if (InHandler !== 1'b0) begin errors++; $display("FAIL idle_inh got=%b exp=0", InHandler); end
        checks++; if (ExcCount !== 16'h0) begin errors++; $display("FAIL idle_cnt got=%h exp=0", ExcCount); end
        checks++; if (ExcVector !== 64'hD8) begin errors++; $display("FAIL vector got=%h exp=d8", ExcVector); end
    endtask

    task automatic test_invalid_opcode();
        // NotAnInstr alone is ignored.
        NotAnInstr = 1'b1;
        #1;
        checks++; if (ExcPCSel !== 2'b00) begin errors++; $display("FAIL nai_ignored got=%b exp=00", ExcPCSel); end
        step();
        checks++; if (InHandler !== 1'b0) begin errors++; $display("FAIL nai_state got=%b exp=0", InHandler); end
        PC_id = 64'h40; EStatus = 4'b0010;
        #1;
        checks++; if (ExcPCSel !== 2'b01) begin errors++; $display("FAIL inv_sel got=%b exp=01", ExcPCSel); end
        step(); takes++;
        EStatus = 4'd0; NotAnInstr = 1'b0;
        checks++; if (ELR !== 64'h40) begin errors++; $display("FAIL inv_elr got=%h exp=40", ELR); end
        checks++; if (ESR !== 4'b0010) begin errors++; $display("FAIL inv_esr got=%b exp=0010", ESR); end
        checks++; if (InHandler !== 1'b1 || IrqAck !== 1'b0) begin errors++; $display("FAIL inv_inh_ack got=%b%b exp=10", InHandler, IrqAck); end
        checks++; if (ExcCount !== exp_cnt()) begin errors++; $display("FAIL inv_cnt got=%h exp=%h", ExcCount, exp_cnt()); end
        // Return.
        ERet = 1'b1;
        #1;
        checks++; if (ExcPCSel !== 2'b10) begin errors++; $display("FAIL inv_ret_sel got=%b exp=10", ExcPCSel); end
        step();
        ERet = 1'b0;
        checks++; if (InHandler !== 1'b0 || ELR !== 64'h40 || ESR !== 4'b0010) begin errors++; $display("FAIL inv_ret got=%b/%h/%b exp=0/40/0010", InHandler, ELR, ESR); end
    endtask

    task automatic test_irq_handshake();
        IrqReq = 1'b1;
        step();
        checks++; if (ExtIRQ !== 1'b0) begin errors++; $display("FAIL irq_edge1 got=%b exp=0", ExtIRQ); end
        step();
        checks++; if (ExtIRQ !== 1'b1) begin errors++; $display("FAIL irq_edge2 got=%b exp=1", ExtIRQ); end
        PC_id = 64'h100; EStatus = 4'b0001;
        #1;
        checks++; if (ExcPCSel !== 2'b01) begin errors++; $display("FAIL irq_sel got=%b exp=01", ExcPCSel); end
        step(); takes++;
        EStatus = 4'd0;
        checks++; if (IrqAck !== 1'b1) begin errors++; $display("FAIL irq_ack got=%b exp=1", IrqAck); end
        checks++; if (ESR !== 4'b0001 || ELR !== 64'h100) begin errors++; $display("FAIL irq_esr_elr got=%b/%h exp=0001/100", ESR, ELR); end
        checks++; if (ExtIRQ !== 1'b0 || InHandler !== 1'b1) begin errors++; $display("FAIL irq_handler got=%b%b exp=01", ExtIRQ, InHandler); end
        step();
        checks++; if (IrqAck !== 1'b0) begin errors++; $display("FAIL irq_ack_width got=%b exp=0", IrqAck); end
    endtask

    task automatic test_return();
        ERet = 1'b1;
        #1;
        checks++; if (ExcPCSel !== 2'b10) begin errors++; $display("FAIL ret_sel got=%b exp=10", ExcPCSel); end
        step();
        ERet = 1'b0;
        checks++; if (InHandler !== 1'b0) begin errors++; $display("FAIL ret_inh got=%b exp=0", InHandler); end
        step();
        checks++; if (ExtIRQ !== 1'b0) begin errors++; $display("FAIL ret_no_new_irq got=%b exp=0", ExtIRQ); end
        IrqReq = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        // Raise, get ExtIRQ, take with the line dropped, re-raise during ack.
        IrqReq = 1'b1;
        step(); step();
        checks++; if (ExtIRQ !== 1'b1) begin errors++; $display("FAIL b2b_extirq got=%b exp=1", ExtIRQ); end
        PC_id = 64'h200; EStatus = 4'b0001; IrqReq = 1'b0;
        step(); takes++;
        EStatus = 4'd0;
        checks++; if (IrqAck !== 1'b1) begin errors++; $display("FAIL b2b_ack got=%b exp=1", IrqAck); end
        IrqReq = 1'b1;
        step();
        checks++; if (IrqAck !== 1'b0 || ExtIRQ !== 1'b0) begin errors++; $display("FAIL b2b_in_handler got=%b%b exp=00", IrqAck, ExtIRQ); end
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        checks++; if (ExtIRQ !== 1'b1 || InHandler !== 1'b0) begin errors++; $display("FAIL b2b_pending_kept got=%b%b exp=10", ExtIRQ, InHandler); end
        // Serve the held request so the line is quiet afterwards.
        PC_id = 64'h300; EStatus = 4'b0001;
        step(); takes++;
        EStatus = 4'd0;
        step();
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        step();
        checks++; if (ExtIRQ !== 1'b0) begin errors++; $display("FAIL b2b_served got=%b exp=0", ExtIRQ); end
        checks++; if (ExcCount !== exp_cnt()) begin errors++; $display("FAIL b2b_cnt got=%h exp=%h", ExcCount, exp_cnt()); end
        IrqReq = 1'b0;
    endtask

    task automatic test_eret_in_run();
        ERet = 1'b1;
        #1;
        checks++; if (ExcPCSel !== 2'b00) begin errors++; $display("FAIL run_eret_sel got=%b exp=00", ExcPCSel); end
        step();
        ERet = 1'b0;
        checks++; if (InHandler !== 1'b0 || Halted !== 1'b0) begin errors++; $display("FAIL run_eret_state got=%b%b exp=00", InHandler, Halted); end
    endtask

    task automatic test_reserved_code();
        PC_id = 64'h480; EStatus = 4'b1000;
        #1;
        checks++; if (ExcPCSel !== 2'b01) begin errors++; $display("FAIL rsv_sel got=%b exp=01", ExcPCSel); end
        step(); takes++;
        EStatus = 4'd0;
        checks++; if (ESR !== 4'b1000 || InHandler !== 1'b1) begin errors++; $display("FAIL rsv_take got=%b/%b exp=1000/1", ESR, InHandler); end
        ERet = 1'b1;
        step();
        ERet = 1'b0;
    endtask

    task automatic test_double_fault();
        PC_id = 64'h500; EStatus = 4'b0010;
        step(); takes++;
        PC_id = 64'h504; EStatus = 4'b0010; ERet = 1'b1;
        #1;
        checks++; if (ExcPCSel !== 2'b11) begin errors++; $display("FAIL df_sel got=%b exp=11", ExcPCSel); end
        step();
        EStatus = 4'd0;
        checks++; if (Halted !== 1'b1 || InHandler !== 1'b0) begin errors++; $display("FAIL df_halt got=%b%b exp=10", Halted, InHandler); end
        checks++; if (ELR !== 64'h500 || ESR !== 4'b0010) begin errors++; $display("FAIL df_regs got=%h/%b exp=500/0010", ELR, ESR); end
        checks++; if (ExcCount !== exp_cnt()) begin errors++; $display("FAIL df_cnt got=%h exp=%h", ExcCount, exp_cnt()); end
        // ERet and IRQ edges are ignored in HALT.
        IrqReq = 1'b1;
        step(); step(); step();
        checks++; if (Halted !== 1'b1 || ExcPCSel !== 2'b11 || ExtIRQ !== 1'b0) begin errors++; $display("FAIL halt_sticky got=%b/%b/%b exp=1/11/0", Halted, ExcPCSel, ExtIRQ); end
        ERet = 1'b0; IrqReq = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (Halted !== 1'b0 || ExcPCSel !== 2'b00 || ELR !== 64'h0) begin errors++; $display("FAIL halt_reset got=%b/%b/%h exp=0/00/0", Halted, ExcPCSel, ELR); end
        takes = 0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset_in_handler();
        PC_id = 64'h600; EStatus = 4'b0010;
        step(); takes++;
        EStatus = 4'd0;
        checks++; if (InHandler !== 1'b1 || ELR !== 64'h600) begin errors++; $display("FAIL mid_pre got=%b/%h exp=1/600", InHandler, ELR); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (InHandler !== 1'b0 || ELR !== 64'h0 || ESR !== 4'h0) begin errors++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0/0", InHandler, ELR, ESR); end
        takes = 0;
        checks++; if (ExcCount !== 16'h0) begin errors++; $display("FAIL mid_cnt got=%h exp=0", ExcCount); end
        step();
        reset = 1'b1;
        step();
        checks++; if (InHandler !== 1'b0 || ExcPCSel !== 2'b00) begin errors++; $display("FAIL mid_after got=%b/%b exp=0/00", InHandler, ExcPCSel); end
    endtask

    initial begin
        test_reset();
        test_invalid_opcode();
        test_irq_handshake();
        test_return();
        test_back_to_back();
        test_eret_in_run();
        test_reserved_code();
        test_double_fault();
        test_reset_in_handler();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
